player_motion_unit: RTL

Responder-side worker for the top-level sequencer's start/done handshake and shared grid read port. On each `start` it turns and moves the player one frame-step from switch inputs. It performs wall collision against the level grid per axis, so the player slides along walls. It presents the new pose on `next_*` for the sequencer to latch.

---
 rtl/player_motion_unit_if.sv | 39 +++
 rtl/player_motion_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_unit_if.sv
// ============================================================================
// Module      : player_motion_unit_if
// Description : Start/done handshake, switch/pose inputs, pose results and
//               shared grid read port between sequencer and motion unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_motion_unit_if;
  logic        start;
  logic        done;
  logic        turn_right;
  logic        turn_left;
  logic        move_forward;
  logic        move_backward;
  logic [13:0] cur_pos_x;
  logic [12:0] cur_pos_y;
  logic [7:0]  cur_angle;
  logic [13:0] next_pos_x;
  logic [12:0] next_pos_y;
  logic [7:0]  next_angle;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out;

  modport master (
    output start, turn_right, turn_left, move_forward, move_backward,
    output cur_pos_x, cur_pos_y, cur_angle, grid_out,
    input  done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y
  );

  modport slave (
    input  start, turn_right, turn_left, move_forward, move_backward,
    input  cur_pos_x, cur_pos_y, cur_angle, grid_out,
    output done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y
  );
endinterface

`default_nettype wire

// File: rtl/player_motion_unit.sv
// ============================================================================
// Module      : player_motion_unit
// Description : Turns and moves the player one frame-step per start request,
//               resolving wall collisions per axis against the level grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_motion_unit #(
  parameter logic [7:0] TURN_STEP  = 8'd2,
  parameter logic [7:0] MOVE_SPEED = 8'd32
) (
  input  logic              clock,
  input  logic              reset,
  player_motion_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ANGLE = 4'd1,
    S_XREQ  = 4'd2,
    S_XWAIT = 4'd3,
    S_XEVAL = 4'd4,
    S_YREQ  = 4'd5,
    S_YWAIT = 4'd6,
    S_YEVAL = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  // Quarter-wave magnitude: round(127*sin(pi/2 * i/64)), i = 0..64
  function automatic logic [6:0] quarter_sin(input logic [6:0] i);
    logic [6:0] m;
    case (i)
      7'd0:  m = 7'd0;   7'd1:  m = 7'd3;   7'd2:  m = 7'd6;   7'd3:  m = 7'd9;
      7'd4:  m = 7'd12;  7'd5:  m = 7'd16;  7'd6:  m = 7'd19;  7'd7:  m = 7'd22;
      7'd8:  m = 7'd25;  7'd9:  m = 7'd28;  7'd10: m = 7'd31;  7'd11: m = 7'd34;
      7'd12: m = 7'd37;  7'd13: m = 7'd40;  7'd14: m = 7'd43;  7'd15: m = 7'd46;
      7'd16: m = 7'd49;  7'd17: m = 7'd51;  7'd18: m = 7'd54;  7'd19: m = 7'd57;
      7'd20: m = 7'd60;  7'd21: m = 7'd63;  7'd22: m = 7'd65;  7'd23: m = 7'd68;
      7'd24: m = 7'd71;  7'd25: m = 7'd73;  7'd26: m = 7'd76;  7'd27: m = 7'd78;
      7'd28: m = 7'd81;  7'd29: m = 7'd83;  7'd30: m = 7'd85;  7'd31: m = 7'd88;
      7'd32: m = 7'd90;  7'd33: m = 7'd92;  7'd34: m = 7'd94;  7'd35: m = 7'd96;
      7'd36: m = 7'd98;  7'd37: m = 7'd100; 7'd38: m = 7'd102; 7'd39: m = 7'd104;
      7'd40: m = 7'd106; 7'd41: m = 7'd107; 7'd42: m = 7'd109; 7'd43: m = 7'd111;
      7'd44: m = 7'd112; 7'd45: m = 7'd113; 7'd46: m = 7'd115; 7'd47: m = 7'd116;
      7'd48: m = 7'd117; 7'd49: m = 7'd118; 7'd50: m = 7'd120; 7'd51: m = 7'd121;
      7'd52: m = 7'd122; 7'd53: m = 7'd122; 7'd54: m = 7'd123; 7'd55: m = 7'd124;
      7'd56: m = 7'd125; 7'd57: m = 7'd125; 7'd58: m = 7'd126; 7'd59: m = 7'd126;
      7'd60: m = 7'd126; 7'd61: m = 7'd127; 7'd62: m = 7'd127; 7'd63: m = 7'd127;
      default: m = 7'd127;
    endcase
    return m;
  endfunction

  // Full-wave sine by mirroring the quarter table in odd quadrants and
  // negating in the lower half-turn.
  function automatic logic signed [7:0] sin8(input logic [7:0] a);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = {1'b0, quarter_sin(idx)};
    return a[7] ? -mag : mag;
  endfunction

  state_t      r_state;
  logic        r_turn_right;
  logic        r_turn_left;
  logic        r_move;
  logic        r_back;
  logic [13:0] r_cx;
  logic [12:0] r_cy;
  logic        r_cx_ok;
  logic        r_cy_ok;
  logic        r_done;
  logic [13:0] r_next_pos_x;
  logic [12:0] r_next_pos_y;
  logic [7:0]  r_next_angle;
  logic [5:0]  r_grid_x;
  logic [4:0]  r_grid_y;

  logic [7:0]         w_na;
  logic signed [7:0]  w_sin;
  logic signed [7:0]  w_cos;
  logic signed [15:0] w_speed;
  logic signed [15:0] w_prod_x;
  logic signed [15:0] w_prod_y;
  logic signed [15:0] w_step_x;
  logic signed [15:0] w_step_y;
  logic signed [15:0] w_dx;
  logic signed [15:0] w_dy;
  logic [15:0]        w_cx;
  logic [15:0]        w_cy;
  logic               w_cx_ok;
  logic               w_cy_ok;
  logic               w_cell_free;
  logic [13:0]        w_nx;
  logic [12:0]        w_ny;

  always_comb begin
    w_na = bus.cur_angle;
    if (r_turn_right && !r_turn_left) begin
      w_na = bus.cur_angle + TURN_STEP;
    end else if (r_turn_left && !r_turn_right) begin
      w_na = bus.cur_angle - TURN_STEP;
    end
  end

  assign w_sin    = sin8(w_na);
  assign w_cos    = sin8(w_na + 8'd64);
  assign w_speed  = {8'd0, MOVE_SPEED};
  assign w_prod_x = w_speed * {{8{w_cos[7]}}, w_cos};
  assign w_prod_y = w_speed * {{8{w_sin[7]}}, w_sin};
  // Floor shift first, then negate: backward steps are not mirror images
  // of forward steps when the product is not a multiple of 128.
  assign w_step_x = w_prod_x >>> 7;
  assign w_step_y = w_prod_y >>> 7;
  assign w_dx     = r_back ? -w_step_x : w_step_x;
  assign w_dy     = r_back ? -w_step_y : w_step_y;

  assign w_cx    = {2'b00, bus.cur_pos_x} + w_dx;
  assign w_cy    = {3'b000, bus.cur_pos_y} + w_dy;
  assign w_cx_ok = (w_cx[15:14] == 2'b00);
  assign w_cy_ok = (w_cy[15:13] == 3'b000);

  assign w_cell_free = (bus.grid_out == 3'd0);
  assign w_nx = (r_cx_ok && w_cell_free) ? r_cx : bus.cur_pos_x;
  assign w_ny = (r_cy_ok && w_cell_free) ? r_cy : bus.cur_pos_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_turn_right <= 1'b0;
      r_turn_left  <= 1'b0;
      r_move       <= 1'b0;
      r_back       <= 1'b0;
      r_cx         <= 14'd0;
      r_cy         <= 13'd0;
      r_cx_ok      <= 1'b0;
      r_cy_ok      <= 1'b0;
      r_done       <= 1'b0;
      r_next_pos_x <= 14'd0;
      r_next_pos_y <= 13'd0;
      r_next_angle <= 8'd0;
      r_grid_x     <= 6'd0;
      r_grid_y     <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_turn_right <= bus.turn_right;
            r_turn_left  <= bus.turn_left;
            r_move       <= bus.move_forward ^ bus.move_backward;
            r_back       <= bus.move_backward;
            r_state      <= S_ANGLE;
          end
        end
        S_ANGLE: begin
          r_next_angle <= w_na;
          r_cx         <= w_cx[13:0];
          r_cy         <= w_cy[12:0];
          r_cx_ok      <= w_cx_ok;
          r_cy_ok      <= w_cy_ok;
          if (r_move) begin
            // A rejected candidate leaves the address bus parked at zero.
            r_grid_x <= w_cx_ok ? w_cx[13:8] : 6'd0;
            r_grid_y <= w_cx_ok ? bus.cur_pos_y[12:8] : 5'd0;
            r_state  <= S_XREQ;
          end else begin
            r_next_pos_x <= bus.cur_pos_x;
            r_next_pos_y <= bus.cur_pos_y;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_XREQ:  r_state <= S_XWAIT;
        S_XWAIT: r_state <= S_XEVAL;
        S_XEVAL: begin
          r_next_pos_x <= w_nx;
          r_grid_x     <= r_cy_ok ? w_nx[13:8] : 6'd0;
          r_grid_y     <= r_cy_ok ? r_cy[12:8] : 5'd0;
          r_state      <= S_YREQ;
        end
        S_YREQ:  r_state <= S_YWAIT;
        S_YWAIT: r_state <= S_YEVAL;
        S_YEVAL: begin
          r_next_pos_y <= w_ny;
          r_grid_x     <= 6'd0;
          r_grid_y     <= 5'd0;
          r_done       <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done       = r_done;
  assign bus.next_pos_x = r_next_pos_x;
  assign bus.next_pos_y = r_next_pos_y;
  assign bus.next_angle = r_next_angle;
  assign bus.grid_x     = r_grid_x;
  assign bus.grid_y     = r_grid_y;

endmodule

`default_nettype wire
